// File: rtl/dmem_responder.sv
// dmem_responder: data-port responder with wait-state grant FSM, byte-enabled
// word array and fixed-latency response pipeline.
module dmem_responder #(
   parameter int DEPTH_WORDS = 4096,
   parameter int GNT_WAIT    = 0,
   parameter int RD_LAT      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
   typedef enum logic {S_IDLE, S_WAIT} state_t;
   state_t state_q, state_d;
   logic [2:0] wcnt_q, wcnt_d;
   logic gnt, in_range, unused_ok;
   logic [AW-1:0] idx;
   logic [31:0] mem_q [DEPTH_WORDS];
   logic [RD_LAT-1:0] vld_q, vld_d, err_q, err_d;
   logic [31:0] dat_q [RD_LAT];
   logic [31:0] dat_d [RD_LAT];
   assign in_range = addr_i[31:2] < DEPTH_L;
   assign idx = addr_i[AW+1:2];
   assign unused_ok = ^addr_i[1:0];
   always_comb begin
      state_d = state_q;
      wcnt_d = wcnt_q;
      gnt = 1'b0;
      case (state_q)
         S_IDLE: if (req_i) begin
            if (GNT_WAIT == 0) gnt = 1'b1;
            else begin
               state_d = S_WAIT;
               wcnt_d = 3'd1;
            end
         end
         default: if (req_i && wcnt_q == 3'(GNT_WAIT)) begin
            gnt = 1'b1;
            state_d = S_IDLE;
            wcnt_d = '0;
         end else if (req_i) wcnt_d = wcnt_q + 3'd1;
         else begin
            // dropped request mid-wait: abandon it without a response
            state_d = S_IDLE;
            wcnt_d = '0;
         end
      endcase
      gnt = gnt & ~rst;
   end
   always_comb begin
      vld_d = (vld_q << 1) | RD_LAT'(gnt);
      err_d = (err_q << 1) | RD_LAT'(gnt & ~in_range);
      dat_d[0] = (gnt && !we_i && in_range) ? mem_q[idx] : '0;
      for (int i = 1; i < RD_LAT; i++) dat_d[i] = dat_q[i-1];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wcnt_q <= '0;
         vld_q <= '0;
         err_q <= '0;
         dat_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         wcnt_q <= wcnt_d;
         vld_q <= vld_d;
         err_q <= err_d;
         dat_q <= dat_d;
      end
   end
   always_ff @(posedge clk) begin
      if (gnt && we_i && in_range)
         for (int b = 0; b < 4; b++)
            if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
   end
   assign gnt_o = gnt;
   assign rvalid_o = vld_q[RD_LAT-1];
   assign err_o = err_q[RD_LAT-1];
   assign rdata_o = dat_q[RD_LAT-1];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks on three configurations sharing one stimulus bus.
module tb_dmem_responder;
   logic clk = 1'b0;
   logic rst, req, we;
   logic [3:0] be;
   logic [31:0] addr, wdata;
   logic g0, v0, e0, g1, v1, e1, g2, v2, e2;
   logic [31:0] d0, d1, d2;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   dmem_responder #(.DEPTH_WORDS(4096), .GNT_WAIT(0), .RD_LAT(1)) u0 (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
      .gnt_o(g0), .rvalid_o(v0), .rdata_o(d0), .err_o(e0));
   dmem_responder #(.DEPTH_WORDS(4096), .GNT_WAIT(3), .RD_LAT(2)) u1 (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
      .gnt_o(g1), .rvalid_o(v1), .rdata_o(d1), .err_o(e1));
   dmem_responder #(.DEPTH_WORDS(4096), .GNT_WAIT(0), .RD_LAT(3)) u2 (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
      .gnt_o(g2), .rvalid_o(v2), .rdata_o(d2), .err_o(e2));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic r, input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
      req = r; we = w; be = b; addr = a; wdata = d;
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      drive(1, 1, 4'hF, a, d);
      tick();
      drive(0, 0, 4'h0, 0, 0);
   endtask
   task automatic idle(input int n);
      drive(0, 0, 4'h0, 0, 0);
      repeat (n) tick();
   endtask
   // holds a read on u1 until its grant, then watches for the response
   task automatic wait_read();
      for (int c = 0; c < 7; c++) begin
         drive(c <= 3, 0, 4'h0, 32'h10, 0);
         @(negedge clk);
         check($sformatf("t3_gnt_c%0d", c), 32'(g1), 32'(c == 3));
         check($sformatf("t3_rv_c%0d", c), 32'(v1), 32'(c == 5));
         tick();
      end
   endtask
   initial begin
      rst = 1'b1;
      drive(1, 0, 4'h0, 32'h10, 0);
      repeat (3) begin
         @(negedge clk);
         check("rst_u0", {g0, v0, e0, 29'd0} | d0, 0);
         check("rst_u2", {g2, v2, e2, 29'd0} | d2, 0);
         tick();
      end
      rst = 1'b0;
      drive(0, 0, 4'h0, 0, 0);
      @(negedge clk);
      check("post_rst_u0", {g0, v0, e0, 29'd0} | d0, 0);
      tick();
      // 1: plain read
      wr(32'h10, 32'hDEADBEEF);
      idle(4);
      drive(1, 0, 4'h0, 32'h10, 0);
      @(negedge clk);
      check("t1_gnt", 32'(g0), 1);
      tick();
      drive(0, 0, 4'h0, 0, 0);
      @(negedge clk);
      check("t1_rv", 32'(v0), 1);
      check("t1_rdata", d0, 32'hDEADBEEF);
      check("t1_err", 32'(e0), 0);
      tick();
      // 2: byte-enable write then read-after-write
      wr(32'h10, 32'h11223344);
      idle(4);
      drive(1, 1, 4'b0101, 32'h10, 32'hAABBCCDD);
      @(negedge clk);
      check("t2_wgnt", 32'(g0), 1);
      tick();
      drive(1, 0, 4'h0, 32'h10, 0);
      @(negedge clk);
      check("t2_wrv", 32'(v0), 1);
      check("t2_wdata", d0, 0);
      tick();
      drive(0, 0, 4'h0, 0, 0);
      @(negedge clk);
      check("t2_rrv", 32'(v0), 1);
      check("t2_rdata", d0, 32'h11BB33DD);
      tick();
      // 4: pipelined reads on u2
      for (int i = 0; i < 4; i++) wr(32'(i * 4), 32'(i));
      idle(5);
      for (int c = 0; c < 7; c++) begin
         drive(c < 4, 0, 4'h0, 32'(c * 4), 0);
         @(negedge clk);
         check($sformatf("t4_gnt_c%0d", c), 32'(g2), 32'(c < 4));
         check($sformatf("t4_rv_c%0d", c), 32'(v2), 32'(c >= 3));
         check($sformatf("t4_data_c%0d", c), d2, c >= 3 ? 32'(c - 3) : 0);
         tick();
      end
      idle(3);
      // 5: out of range on u0
      wr(32'h3FFC, 32'h12345678);
      idle(4);
      drive(1, 1, 4'hF, 32'h4000, 32'hFFFFFFFF);
      tick();
      drive(1, 0, 4'h0, 32'h4000, 0);
      @(negedge clk);
      check("t5_w_err", {31'd0, e0} | (32'(v0) << 4), 32'h11);
      check("t5_w_data", d0, 0);
      tick();
      drive(1, 0, 4'h0, 32'h3FFC, 0);
      @(negedge clk);
      check("t5_r_err", {31'd0, e0} | (32'(v0) << 4), 32'h11);
      check("t5_r_data", d0, 0);
      tick();
      drive(1, 0, 4'h0, 32'h0, 0);
      @(negedge clk);
      check("t5_ok_err", {31'd0, e0} | (32'(v0) << 4), 32'h10);
      check("t5_ok_data", d0, 32'h12345678);
      tick();
      drive(0, 0, 4'h0, 0, 0);
      @(negedge clk);
      check("t5_word0", d0, 0);
      tick();
      // 3: wait states on u1
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      wait_read();
      drive(1, 0, 4'h0, 32'h10, 0);
      tick();
      for (int c = 1; c < 6; c++) begin
         drive(0, 0, 4'h0, 0, 0);
         @(negedge clk);
         check($sformatf("t3_drop_gnt_c%0d", c), 32'(g1), 0);
         check($sformatf("t3_drop_rv_c%0d", c), 32'(v1), 0);
         tick();
      end
      wait_read();
      // 6: reset mid-flight on u2
      idle(4);
      drive(1, 0, 4'h0, 32'h4, 0);
      @(negedge clk);
      check("t6_gnt", 32'(g2), 1);
      tick();
      drive(0, 0, 4'h0, 0, 0);
      rst = 1'b1;
      for (int c = 1; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("t6_rv_c%0d", c), 32'(v2), 0);
         tick();
         rst = 1'b0;
      end
      drive(1, 0, 4'h0, 32'h8, 0);
      @(negedge clk);
      check("t6_gnt2", 32'(g2), 1);
      tick();
      drive(0, 0, 4'h0, 0, 0);
      tick();
      tick();
      @(negedge clk);
      check("t6_rv2", 32'(v2), 1);
      check("t6_data2", d2, 2);
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
